// File: rtl/tpu_sequencer.sv
// tpu_sequencer: job controller for a KxK systolic array (weight load, vector stream, drain, done).
// Optional perf counters perf_cycles/perf_stalls are built when TPU_SEQ_PERF_EN is defined.
//
// state    | meaning
// S_IDLE   | waiting for start, nothing in flight
// S_LOAD_W | accepting weight rows 0..K-1
// S_STREAM | accepting num_vecs data vectors
// S_DRAIN  | waiting for the latency pipe to empty
// S_DONE   | one-cycle completion pulse
module tpu_sequencer #(
  parameter int K     = 2,
  parameter int LEN_W = 8,
  parameter int LAT   = 2 * K
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [LEN_W-1:0]     num_vecs,
  input  logic                 abort,
  input  logic                 w_valid,
  output logic                 w_ready,
  output logic [$clog2(K)-1:0] w_row,
  output logic                 load_weights,
  input  logic                 d_valid,
  output logic                 d_ready,
  output logic                 pe_valid,
  output logic                 out_valid,
  output logic                 busy,
  output logic                 done
`ifdef TPU_SEQ_PERF_EN
  ,
  output logic [31:0]          perf_cycles,
  output logic [15:0]          perf_stalls
`endif
);

  localparam int ROW_W = $clog2(K);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_W,
    S_STREAM,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t             state, state_nxt;
  logic [ROW_W-1:0]   row_cnt;
  logic [LEN_W-1:0]   vec_left;
  logic [LAT-1:0]     lat_pipe;
  logic               abort_job;
  logic               last_row;
  logic               last_vec;

  assign abort_job = abort && (state != S_IDLE);
  assign last_row  = (row_cnt == ROW_W'(K - 1));
  // vec_left counts down from num_vecs; compare against 1 so 2^LEN_W-1 never wraps
  assign last_vec  = (vec_left == LEN_W'(1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    w_ready   = 1'b0;
    d_ready   = 1'b0;
    done      = 1'b0;
    busy      = (state != S_IDLE);
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = (num_vecs != '0) ? S_LOAD_W : S_DONE;
        end
      end
      S_LOAD_W: begin
        w_ready = 1'b1;
        if (w_valid && last_row) begin
          state_nxt = S_STREAM;
        end
      end
      S_STREAM: begin
        d_ready = 1'b1;
        if (d_valid && last_vec) begin
          state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (lat_pipe == '0) begin
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
    // Abort wins over any same-cycle handshake, so readies drop with it.
    if (abort_job) begin
      state_nxt = S_IDLE;
      w_ready   = 1'b0;
      d_ready   = 1'b0;
    end
  end

  assign load_weights = w_valid && w_ready;
  assign pe_valid     = d_valid && d_ready;
  assign out_valid    = lat_pipe[LAT-1];
  assign w_row        = row_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row_cnt  <= '0;
      vec_left <= '0;
      lat_pipe <= '0;
    end else if (abort_job) begin
      row_cnt  <= '0;
      vec_left <= '0;
      lat_pipe <= '0;
    end else begin
      if ((state == S_IDLE) && start) begin
        vec_left <= num_vecs;
      end
      if (load_weights) begin
        row_cnt <= last_row ? '0 : row_cnt + ROW_W'(1);
      end
      if (pe_valid) begin
        vec_left <= vec_left - LEN_W'(1);
      end
      lat_pipe <= {lat_pipe[LAT-2:0], pe_valid};
    end
  end

`ifdef TPU_SEQ_PERF_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_cycles <= '0;
      perf_stalls <= '0;
    end else if ((state == S_IDLE) && start) begin
      perf_cycles <= '0;
      perf_stalls <= '0;
    end else begin
      if (busy && (perf_cycles != '1)) begin
        perf_cycles <= perf_cycles + 32'd1;
      end
      if ((state == S_STREAM) && !d_valid && (perf_stalls != '1)) begin
        perf_stalls <= perf_stalls + 16'd1;
      end
    end
  end
`endif

endmodule
